jesd204_rx_err_statistics: RTL and testbench



---
 rtl/jesd204_rx_err_statistics.sv | 93 +++++++++
 tb/tb_jesd204_rx_err_statistics.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204_rx_err_statistics.sv
// Per-lane JESD204 receive error-statistics counters.
// Each lane runs a three-stage pipeline: a filtered per-octet error vector,
// its popcount, and a 32-bit saturating accumulator. The output bus is
// driven straight from the accumulator registers.
module jesd204_rx_err_statistics #(
    parameter int NUM_LANES       = 1,
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_LANES-1:0]                 cfg_lanes_disable,
    input  logic                                 ctrl_err_statistics_reset,
    input  logic [6:0]                           ctrl_err_statistics_mask,
    input  logic [NUM_LANES*DATA_PATH_WIDTH-1:0] phy_disperr,
    input  logic [NUM_LANES*DATA_PATH_WIDTH-1:0] phy_notintable,
    input  logic [NUM_LANES*DATA_PATH_WIDTH-1:0] phy_unexpected_k,
    output logic [32*NUM_LANES-1:0]              status_err_statistics_cnt
);

    localparam int DPW = DATA_PATH_WIDTH;
    localparam int CW  = $clog2(DATA_PATH_WIDTH + 1);

    // Either reset source flushes every stage and counter on the same edge.
    logic w_clear;
    assign w_clear = reset | ctrl_err_statistics_reset;

    // Mask bits 3..6 are reserved and have no effect.
    logic w_unused_mask;
    assign w_unused_mask = ^ctrl_err_statistics_mask[6:3];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [DPW-1:0] w_err;
            logic [DPW-1:0] r_err;
            logic [CW-1:0]  w_pop;
            logic [CW-1:0]  r_pop;
            logic [32:0]    w_sum;
            logic [31:0]    r_cnt;

            // Merge the three error classes per octet; a multi-class octet counts once.
            always_comb begin
                w_err = ((phy_disperr[gi*DPW +: DPW]      & {DPW{~ctrl_err_statistics_mask[0]}}) |
                         (phy_notintable[gi*DPW +: DPW]   & {DPW{~ctrl_err_statistics_mask[1]}}) |
                         (phy_unexpected_k[gi*DPW +: DPW] & {DPW{~ctrl_err_statistics_mask[2]}}))
                        & {DPW{~cfg_lanes_disable[gi]}};
            end

            // Stage 1: register the filtered error vector.
            always_ff @(posedge clk) begin
                if (w_clear) begin
                    r_err <= '0;
                end else begin
                    r_err <= w_err;
                end
            end

            // Count the flagged octets of the stage-1 vector.
            always_comb begin
                w_pop = '0;
                for (int j = 0; j < DPW; j++) begin
                    w_pop = w_pop + CW'(r_err[j]);
                end
            end

            // Stage 2: register the popcount.
            always_ff @(posedge clk) begin
                if (w_clear) begin
                    r_pop <= '0;
                end else begin
                    r_pop <= w_pop;
                end
            end

            // A carry out of bit 31 means the counter has reached full scale.
            assign w_sum = {1'b0, r_cnt} + 33'(r_pop);

            // Stage 3: saturating accumulator; clear wins over any increment.
            always_ff @(posedge clk) begin
                if (w_clear) begin
                    r_cnt <= '0;
                end else if (w_sum[32]) begin
                    r_cnt <= 32'hFFFF_FFFF;
                end else begin
                    r_cnt <= w_sum[31:0];
                end
            end

            assign status_err_statistics_cnt[32*gi +: 32] = r_cnt;
        end
    endgenerate

endmodule

// File: tb/tb_jesd204_rx_err_statistics.sv
// Self-checking bench for jesd204_rx_err_statistics (2 lanes, 4 octets/beat).
// A behavioural model derives each lane count from the beats it has seen,
// and directed scenarios pin the model with hand-computed values.
module tb_jesd204_rx_err_statistics;

    localparam int NL  = 2;
    localparam int DPW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [NL-1:0]       dis;
    logic                ctrl_clr;
    logic [6:0]          mask;
    logic [NL*DPW-1:0]   disp;
    logic [NL*DPW-1:0]   nit;
    logic [NL*DPW-1:0]   uk;
    logic [32*NL-1:0]    cnt;

    jesd204_rx_err_statistics #(
        .NUM_LANES      (NL),
        .DATA_PATH_WIDTH(DPW)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .cfg_lanes_disable        (dis),
        .ctrl_err_statistics_reset(ctrl_clr),
        .ctrl_err_statistics_mask (mask),
        .phy_disperr              (disp),
        .phy_notintable           (nit),
        .phy_unexpected_k         (uk),
        .status_err_statistics_cnt(cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // Preload support for saturation tests (lane 0 only).
    logic        force_pending = 1'b0;
    logic [31:0] force_val     = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each beat contributes the number of octets that carry at least one
    // unmasked error on an enabled lane. That contribution lands on the
    // output two edges after the beat is sampled; clears wipe counts and
    // every beat not yet landed.
    logic [31:0]        m_cnt [NL];
    logic [NL*8-1:0]    beat_q [$];

    initial begin
        logic [NL*8-1:0] b;
        logic [NL*8-1:0] old;
        longint          s;
        int              n;
        int              idx;
        for (int l = 0; l < NL; l++) m_cnt[l] = '0;
        forever begin
            @(posedge clk);
            if (reset || ctrl_clr) begin
                for (int l = 0; l < NL; l++) m_cnt[l] = '0;
                beat_q.delete();
            end else begin
                b = '0;
                for (int l = 0; l < NL; l++) begin
                    n = 0;
                    if (!dis[l]) begin
                        for (int j = 0; j < DPW; j++) begin
                            idx = l * DPW + j;
                            if ((disp[idx] && !mask[0]) || (nit[idx] && !mask[1]) ||
                                (uk[idx] && !mask[2]))
                                n++;
                        end
                    end
                    b[l*8 +: 8] = 8'(n);
                end
                beat_q.push_back(b);
                if (beat_q.size() > 2) begin
                    old = beat_q.pop_front();
                    for (int l = 0; l < NL; l++) begin
                        s = longint'(m_cnt[l]) + longint'(old[l*8 +: 8]);
                        m_cnt[l] = (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
                    end
                end
                if (force_pending) m_cnt[0] = force_val;
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int l = 0; l < NL; l++)
                    check($sformatf("model_lane%0d", l), cnt[l*32 +: 32], m_cnt[l]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic zero_errs();
        disp = '0;
        nit  = '0;
        uk   = '0;
    endtask

    task automatic do_clear();
        ctrl_clr = 1'b1;
        tick();
        ctrl_clr = 1'b0;
    endtask

    // Preload lane 0 with pipeline drained, then apply full-lane beats.
    task automatic sat_case(input string name, input logic [31:0] v, input int beats,
                            input logic [31:0] exp);
        zero_errs();
        tick(3);
        force_val     = v;
        force_pending = 1'b1;
        force dut.g_lane[0].r_cnt = force_val;
        tick();
        release dut.g_lane[0].r_cnt;
        force_pending = 1'b0;
        disp = 8'h0F;
        tick(beats);
        zero_errs();
        tick(2);
        check(name, cnt[31:0], exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        dis      = '0;
        ctrl_clr = 1'b0;
        mask     = '0;
        zero_errs();
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_lane0", cnt[31:0], 32'd0);
        check("reset_lane1", cnt[63:32], 32'd0);
        reset = 1'b0;
        tick(2);

        // Basic count: two flagged octets on lane 0 for one beat.
        disp = 8'b0000_0101;
        tick();
        zero_errs();
        tick();
        check("basic_early", cnt[31:0], 32'd0);
        tick();
        check("basic_lane0", cnt[31:0], 32'd2);
        check("basic_lane1", cnt[63:32], 32'd0);

        // Mask and overlap: disparity masked, two octets remain per beat.
        do_clear();
        mask = 7'b000_0001;
        disp = 8'h0F; nit = 8'h03; uk = 8'h02;
        tick(10);
        zero_errs();
        tick(2);
        check("mask_001", cnt[31:0], 32'd20);
        mask = 7'b000_0111;
        disp = 8'h0F; nit = 8'h03; uk = 8'h02;
        tick(10);
        zero_errs();
        tick(2);
        check("mask_111", cnt[31:0], 32'd20);
        mask = 7'b111_1000;
        disp = 8'h01;
        tick();
        zero_errs();
        tick(2);
        check("mask_reserved", cnt[31:0], 32'd21);
        mask = '0;

        // Lane disable: lane 1 holds at 7 while lane 0 keeps counting.
        do_clear();
        disp = 8'b0111_0000;
        tick();
        disp = 8'hF0;
        tick();
        zero_errs();
        tick(2);
        check("dis_pre_lane1", cnt[63:32], 32'd7);
        dis  = 2'b10;
        disp = 8'hFF; nit = 8'hFF; uk = 8'hFF;
        tick(5);
        zero_errs();
        tick(2);
        check("dis_hold_lane1", cnt[63:32], 32'd7);
        check("dis_run_lane0", cnt[31:0], 32'd20);
        dis = '0;

        // Clear versus continuous increment.
        do_clear();
        disp = 8'h0F;
        tick(12);
        check("clr_pre", cnt[31:0], 32'd40);
        ctrl_clr = 1'b1;
        tick();
        ctrl_clr = 1'b0;
        check("clr_edge", cnt[31:0], 32'd0);
        tick();
        check("clr_plus1", cnt[31:0], 32'd0);
        tick();
        check("clr_plus2", cnt[31:0], 32'd0);
        tick();
        check("clr_first", cnt[31:0], 32'd4);
        zero_errs();

        // Synchronous reset while counting.
        disp = 8'hFF;
        tick(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_lane0", cnt[31:0], 32'd0);
        check("rst_mid_lane1", cnt[63:32], 32'd0);
        zero_errs();

        // Saturation boundaries on lane 0.
        sat_case("sat_below",   32'hFFFF_FFF0, 1,   32'hFFFF_FFF4);
        sat_case("sat_exact",   32'hFFFF_FFFC, 1,   32'hFFFF_FFFF);
        sat_case("sat_clamp",   32'hFFFF_FFFE, 1,   32'hFFFF_FFFF);
        sat_case("sat_hold",    32'hFFFF_FFFD, 101, 32'hFFFF_FFFF);

        // Randomised traffic against the model.
        do_clear();
        for (int c = 0; c < 1500; c++) begin
            disp = NL*DPW'($urandom);
            nit  = NL*DPW'($urandom);
            uk   = NL*DPW'($urandom);
            if ($urandom_range(0, 9) == 0)   mask = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 19) == 0)  dis  = NL'($urandom_range(0, 3));
            ctrl_clr = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            tick();
        end
        ctrl_clr = 1'b0;
        reset    = 1'b0;
        zero_errs();
        tick(3);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
